// File: rtl/acq_write_controller.sv
// Write-side controller for the acquisition sample buffer: circular RAM writes with
// pre-trigger history, trigger address capture and a bounded post-trigger count.
module acq_write_controller #(
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic [ADDR_WIDTH:0]   pretrig_len,
   input  logic [ADDR_WIDTH:0]   posttrig_len,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic                  sample_valid,
   input  logic                  trigger,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] din,
   output logic                  write_en,
   output logic                  busy,
   output logic                  armed,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic [ADDR_WIDTH-1:0] start_addr
);

   localparam int unsigned LW = ADDR_WIDTH + 1;

   typedef logic [LW-1:0] len_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

   localparam len_t DepthLen = len_t'(2 ** ADDR_WIDTH);
   localparam len_t OneLen   = len_t'(1);

   typedef enum logic [2:0] {StIdle, StPretrig, StWaitTrig, StPosttrig, StDone} state_e;

   state_e                state_q, state_d;
   addr_t                 wptr_q, wptr_d;
   len_t                  cnt_q, cnt_d;
   len_t                  pre_eff_q, pre_eff_d;
   len_t                  post_eff_q, post_eff_d;
   addr_t                 trig_addr_q, trig_addr_d;
   addr_t                 start_addr_q, start_addr_d;
   addr_t                 waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic                  write_en_q, write_en_d;
   logic                  busy_q, busy_d;
   logic                  armed_q, armed_d;
   logic                  done_q, done_d;

   len_t                  pre_clamp, post_clamp, post_fit;
   logic [LW:0]           len_sum;
   logic                  wr_state, accept, do_write;

   always_comb begin
      pre_clamp  = (pretrig_len > DepthLen) ? DepthLen : pretrig_len;
      post_clamp = (posttrig_len > DepthLen) ? DepthLen : posttrig_len;
      len_sum    = {1'b0, pre_clamp} + {1'b0, post_clamp};
      // Post-trigger length shrinks so the whole capture never overwrites its own history.
      post_fit   = (len_sum > {1'b0, DepthLen}) ? (DepthLen - pre_clamp) : post_clamp;
   end

   assign wr_state = (state_q == StPretrig) || (state_q == StWaitTrig) ||
                     (state_q == StPosttrig);
   assign accept   = wr_state && sample_valid && !start && !stop;

   always_comb begin
      state_d      = state_q;
      wptr_d       = wptr_q;
      cnt_d        = cnt_q;
      pre_eff_d    = pre_eff_q;
      post_eff_d   = post_eff_q;
      trig_addr_d  = trig_addr_q;
      start_addr_d = start_addr_q;
      do_write     = 1'b0;

      if (stop) begin
         state_d = StIdle;
      end else if (start) begin
         state_d      = (pre_clamp == '0) ? StWaitTrig : StPretrig;
         wptr_d       = '0;
         cnt_d        = '0;
         pre_eff_d    = pre_clamp;
         post_eff_d   = post_fit;
         trig_addr_d  = '0;
         start_addr_d = '0;
      end else begin
         unique case (state_q)
            StPretrig: begin
               if (accept) begin
                  do_write = 1'b1;
                  if (cnt_q + OneLen == pre_eff_q) begin
                     state_d = StWaitTrig;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + OneLen;
                  end
               end
            end
            StWaitTrig: begin
               if (trigger) begin
                  trig_addr_d  = wptr_q;
                  start_addr_d = wptr_q - pre_eff_q[ADDR_WIDTH-1:0];
                  if (post_eff_q == '0) begin
                     state_d = StDone;
                  end else begin
                     // The trigger-cycle sample, if any, is post-trigger sample #1.
                     do_write = accept;
                     cnt_d    = accept ? OneLen : '0;
                     state_d  = (accept && (post_eff_q == OneLen)) ? StDone : StPosttrig;
                  end
               end else begin
                  do_write = accept;
               end
            end
            StPosttrig: begin
               if (accept) begin
                  do_write = 1'b1;
                  cnt_d    = cnt_q + OneLen;
                  if (cnt_q + OneLen == post_eff_q) begin
                     state_d = StDone;
                  end
               end
            end
            default: ;
         endcase
      end

      if (do_write) begin
         wptr_d = wptr_q + addr_t'(1);
      end

      write_en_d = do_write;
      waddr_d    = do_write ? wptr_q : waddr_q;
      din_d      = do_write ? sample_in : din_q;
      busy_d     = (state_d == StPretrig) || (state_d == StWaitTrig) ||
                   (state_d == StPosttrig);
      armed_d    = (state_d == StWaitTrig);
      done_d     = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         wptr_q       <= '0;
         cnt_q        <= '0;
         pre_eff_q    <= '0;
         post_eff_q   <= '0;
         trig_addr_q  <= '0;
         start_addr_q <= '0;
         waddr_q      <= '0;
         din_q        <= '0;
         write_en_q   <= 1'b0;
         busy_q       <= 1'b0;
         armed_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         cnt_q        <= cnt_d;
         pre_eff_q    <= pre_eff_d;
         post_eff_q   <= post_eff_d;
         trig_addr_q  <= trig_addr_d;
         start_addr_q <= start_addr_d;
         waddr_q      <= waddr_d;
         din_q        <= din_d;
         write_en_q   <= write_en_d;
         busy_q       <= busy_d;
         armed_q      <= armed_d;
         done_q       <= done_d;
      end
   end

   assign waddr      = waddr_q;
   assign din        = din_q;
   assign write_en   = write_en_q;
   assign busy       = busy_q;
   assign armed      = armed_q;
   assign done       = done_q;
   assign trig_addr  = trig_addr_q;
   assign start_addr = start_addr_q;

endmodule

// File: tb/tb_acq_write_controller.sv
// Directed bench for acq_write_controller: one task per scenario, hand-computed expectations.
module tb_acq_write_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [9:0] pretrig_len = '0;
   logic [9:0] posttrig_len = '0;
   logic [7:0] sample_in = '0;
   logic       sample_valid = 1'b0;
   logic       trigger = 1'b0;
   logic [8:0] waddr;
   logic [7:0] din;
   logic       write_en;
   logic       busy;
   logic       armed;
   logic       done;
   logic [8:0] trig_addr;
   logic [8:0] start_addr;

   int n_vec = 0;
   int n_err = 0;

   // Write log gathered from the RAM-side port.
   logic [7:0] ram [512];
   int         wr_cnt = 0;
   logic [8:0] last_addr = '0;
   logic [7:0] last_din = '0;
   int         wr_base;

   acq_write_controller #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .pretrig_len  (pretrig_len),
      .posttrig_len (posttrig_len),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .trigger      (trigger),
      .waddr        (waddr),
      .din          (din),
      .write_en     (write_en),
      .busy         (busy),
      .armed        (armed),
      .done         (done),
      .trig_addr    (trig_addr),
      .start_addr   (start_addr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (write_en) begin
         ram[waddr] = din;
         wr_cnt     = wr_cnt + 1;
         last_addr  = waddr;
         last_din   = din;
      end
   end

   task automatic step(input logic v, input logic [7:0] d, input logic t);
      sample_valid = v;
      sample_in    = d;
      trigger      = t;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int pre, input int post, input logic v, input logic [7:0] d,
                           input logic t);
      pretrig_len  = 10'(pre);
      posttrig_len = 10'(post);
      start        = 1'b1;
      step(v, d, t);
      start        = 1'b0;
      wr_base      = wr_cnt;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      settle();
      n_vec++;
      if ({write_en, busy, armed, done} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags got %b want 0000", {write_en, busy, armed, done});
      end
      n_vec++;
      if ({waddr, din, trig_addr, start_addr} !== 35'd0) begin
         n_err++; $display("FAIL reset_buses got %h want 0", {waddr, din, trig_addr, start_addr});
      end
      rst = 1'b1;
      step(1'b0, 8'h00, 1'b0);
   endtask

   // Valid every cycle including the start cycle; trigger on the 6th valid.
   task automatic test_basic();
      do_start(4, 4, 1'b1, 8'h10, 1'b0);
      for (int k = 1; k <= 12; k++) step(1'b1, 8'(8'h10 + k), (k == 5));
      step(1'b0, 8'h00, 1'b0);
      settle();
      n_vec++;
      if (wr_cnt - wr_base != 8) begin
         n_err++; $display("FAIL basic_writes got %0d want 8", wr_cnt - wr_base);
      end
      n_vec++;
      if (trig_addr !== 9'd4 || start_addr !== 9'd0) begin
         n_err++; $display("FAIL basic_addrs got %0d/%0d want 4/0", trig_addr, start_addr);
      end
      n_vec++;
      if (ram[0] !== 8'h11 || ram[4] !== 8'h15 || ram[7] !== 8'h18 || last_addr !== 9'd7) begin
         n_err++;
         $display("FAIL basic_data got %h %h %h @%0d want 11 15 18 @7", ram[0], ram[4], ram[7],
                  last_addr);
      end
      n_vec++;
      if ({done, busy, armed} !== 3'b100) begin
         n_err++; $display("FAIL basic_done got %b want 100", {done, busy, armed});
      end
   endtask

   task automatic test_late_trigger();
      do_start(4, 4, 1'b0, 8'h00, 1'b0);
      for (int n = 1; n <= 20; n++) step(1'b1, 8'(n), 1'b0);
      settle();
      n_vec++;
      if ({busy, armed, done} !== 3'b110) begin
         n_err++; $display("FAIL late_armed got %b want 110", {busy, armed, done});
      end
      for (int n = 21; n <= 30; n++) step(1'b1, 8'(n), (n == 21));
      settle();
      n_vec++;
      if (wr_cnt - wr_base != 24 || last_addr !== 9'd23 || last_din !== 8'd24) begin
         n_err++;
         $display("FAIL late_writes got %0d @%0d=%0d want 24 @23=24", wr_cnt - wr_base,
                  last_addr, last_din);
      end
      n_vec++;
      if (trig_addr !== 9'd20 || start_addr !== 9'd16) begin
         n_err++; $display("FAIL late_addrs got %0d/%0d want 20/16", trig_addr, start_addr);
      end
   endtask

   task automatic test_wrap_clamp();
      do_start(300, 400, 1'b0, 8'h00, 1'b0);
      for (int n = 1; n <= 500; n++) step(1'b1, 8'(n), 1'b0);
      settle();
      n_vec++;
      if (armed !== 1'b1) begin
         n_err++; $display("FAIL wrap_armed got %b want 1", armed);
      end
      for (int n = 501; n <= 800; n++) step(1'b1, 8'(n), (n == 501));
      settle();
      n_vec++;
      if (wr_cnt - wr_base != 712) begin
         n_err++; $display("FAIL wrap_writes got %0d want 712", wr_cnt - wr_base);
      end
      n_vec++;
      if (last_addr !== 9'd199 || last_din !== 8'd200) begin
         n_err++; $display("FAIL wrap_last got @%0d=%0d want @199=200", last_addr, last_din);
      end
      n_vec++;
      if (trig_addr !== 9'd500 || start_addr !== 9'd200 || done !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_addrs got %0d/%0d done=%b want 500/200 done=1", trig_addr,
                  start_addr, done);
      end
   endtask

   task automatic test_trigger_held();
      do_start(8, 2, 1'b0, 8'h00, 1'b1);
      for (int n = 1; n <= 15; n++) step(1'b1, 8'(8'h40 + n), 1'b1);
      step(1'b0, 8'h00, 1'b0);
      settle();
      n_vec++;
      if (trig_addr !== 9'd8 || start_addr !== 9'd0) begin
         n_err++; $display("FAIL held_addrs got %0d/%0d want 8/0", trig_addr, start_addr);
      end
      n_vec++;
      if (wr_cnt - wr_base != 10 || last_addr !== 9'd9 || ram[8] !== 8'h49) begin
         n_err++;
         $display("FAIL held_writes got %0d @%0d ram8=%h want 10 @9 ram8=49", wr_cnt - wr_base,
                  last_addr, ram[8]);
      end
   endtask

   task automatic test_zero_lengths();
      do_start(0, 0, 1'b1, 8'h77, 1'b0);
      settle();
      n_vec++;
      if ({busy, armed, done} !== 3'b110) begin
         n_err++; $display("FAIL zero_armed got %b want 110", {busy, armed, done});
      end
      step(1'b1, 8'h78, 1'b1);
      for (int n = 0; n < 4; n++) step(1'b1, 8'h79, 1'b0);
      settle();
      n_vec++;
      if (wr_cnt - wr_base != 0 || done !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL zero_done got writes=%0d done=%b busy=%b want 0 1 0", wr_cnt - wr_base,
                  done, busy);
      end
      n_vec++;
      if (trig_addr !== 9'd0 || start_addr !== 9'd0) begin
         n_err++; $display("FAIL zero_addrs got %0d/%0d want 0/0", trig_addr, start_addr);
      end
   endtask

   task automatic test_stop_and_reset();
      do_start(2, 10, 1'b0, 8'h00, 1'b0);
      for (int n = 1; n <= 5; n++) step(1'b1, 8'(8'h60 + n), (n == 3));
      stop = 1'b1;
      step(1'b1, 8'h66, 1'b0);
      stop = 1'b0;
      settle();
      n_vec++;
      if ({write_en, busy, armed, done} !== 4'b0000) begin
         n_err++; $display("FAIL stop_flags got %b want 0000", {write_en, busy, armed, done});
      end
      for (int n = 0; n < 3; n++) step(1'b1, 8'h67, 1'b1);
      settle();
      n_vec++;
      if (wr_cnt - wr_base != 5 || trig_addr !== 9'd2) begin
         n_err++;
         $display("FAIL stop_writes got %0d trig=%0d want 5 trig=2", wr_cnt - wr_base, trig_addr);
      end
      do_start(2, 10, 1'b0, 8'h00, 1'b0);
      for (int n = 1; n <= 4; n++) step(1'b1, 8'(8'h80 + n), (n == 3));
      rst = 1'b0;
      step(1'b1, 8'h85, 1'b0);
      settle();
      n_vec++;
      if ({write_en, busy, armed, done} !== 4'b0000) begin
         n_err++; $display("FAIL rst_flags got %b want 0000", {write_en, busy, armed, done});
      end
      n_vec++;
      if ({waddr, din, trig_addr, start_addr} !== 35'd0) begin
         n_err++; $display("FAIL rst_buses got %h want 0", {waddr, din, trig_addr, start_addr});
      end
      rst = 1'b1;
      step(1'b1, 8'h86, 1'b0);
      settle();
      n_vec++;
      if ({write_en, busy} !== 2'b00) begin
         n_err++; $display("FAIL rst_idle got %b want 00", {write_en, busy});
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_late_trigger();
      test_wrap_clamp();
      test_trigger_held();
      test_zero_lengths();
      test_stop_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
